cursor_ctrl: RTL

CURSOR_CTRL -- requirements
Module: cursor_ctrl

---
 rtl/tictactoe_pkg.sv | 11 +
 rtl/btn_debounce.sv | 27 ++
 rtl/cursor_ctrl.sv | 82 ++++++++
 3 files changed

// File: rtl/tictactoe_pkg.sv
// tictactoe_pkg: shared board constants, cursor reset cell and cursor FSM encodings.
package tictactoe_pkg;
  localparam int NUM_CELLS = 9;
  localparam int GRID_W = 18;
  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_P1 = 2'b01;
  localparam logic [1:0] CELL_P2 = 2'b10;
  localparam logic [3:0] CURSOR_RESET = 4'd4;
  typedef enum logic [1:0] {IDLE, EXEC, LOCK} state_t;
  typedef enum logic [2:0] {CMD_NONE, CMD_S, CMD_U, CMD_D, CMD_L, CMD_R} cmd_t;
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchronizer plus counter that flips the level after DEBOUNCE_CYCLES disagreeing samples.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  logic [1:0] sync;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= '0;
      cnt <= '0;
      level <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      if (sync[1] == level) cnt <= '0;
      else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        cnt <= '0;
        level <= ~level;
      end else cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/cursor_ctrl.sv
// cursor_ctrl: debounced button handling, cursor movement and select commit/reject pulses.
// CURSOR_WRAP_EN: moves past a board edge wrap to the opposite edge instead of stalling.
module cursor_ctrl
  import tictactoe_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btnU,
  input  logic              btnD,
  input  logic              btnL,
  input  logic              btnR,
  input  logic              btnS,
  input  logic [GRID_W-1:0] grid,
  input  logic              mode,
  output logic [3:0]        cursorPos,
  output logic              set,
  output logic              reject
);
`ifdef CURSOR_WRAP_EN
  localparam logic WRAP = 1'b1;
`else
  localparam logic WRAP = 1'b0;
`endif
  logic [4:0] raw, lvl, lvl_d, evt;
  state_t state, state_n;
  cmd_t cmd, cmd_n, pri;
  logic [3:0] pos_n, col, up, dn, lf, rt;
  logic set_n, rej_n, occ;
  assign raw = {btnS, btnU, btnD, btnL, btnR};
  for (genvar i = 0; i < 5; i++) begin : g_btn
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk(clk), .rst(rst), .raw(raw[i]), .level(lvl[i])
    );
  end
  assign evt = lvl & ~lvl_d;
  assign pri = evt[4] ? CMD_S : evt[3] ? CMD_U : evt[2] ? CMD_D : evt[1] ? CMD_L : evt[0] ? CMD_R : CMD_NONE;
  assign col = cursorPos % 4'd3;
  assign up = cursorPos >= 4'd3 ? cursorPos - 4'd3 : WRAP ? cursorPos + 4'd6 : cursorPos;
  assign dn = cursorPos <= 4'd5 ? cursorPos + 4'd3 : WRAP ? cursorPos - 4'd6 : cursorPos;
  assign lf = col != 4'd0 ? cursorPos - 4'd1 : WRAP ? cursorPos + 4'd2 : cursorPos;
  assign rt = col != 4'd2 ? cursorPos + 4'd1 : WRAP ? cursorPos - 4'd2 : cursorPos;
  assign occ = grid[{cursorPos, 1'b0} +: 2] != CELL_EMPTY;
  always_comb begin
    state_n = state;
    cmd_n = cmd;
    pos_n = cursorPos;
    set_n = 1'b0;
    rej_n = 1'b0;
    case (state)
      IDLE: if (pri != CMD_NONE) begin
        state_n = EXEC;
        cmd_n = pri;
      end
      EXEC: begin
        state_n = LOCK;
        set_n = cmd == CMD_S && (mode || !occ);
        rej_n = cmd == CMD_S && !mode && occ;
        pos_n = cmd == CMD_U ? up : cmd == CMD_D ? dn : cmd == CMD_L ? lf : cmd == CMD_R ? rt : cursorPos;
      end
      default: state_n = |lvl ? LOCK : IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cmd <= CMD_NONE;
      cursorPos <= CURSOR_RESET;
      set <= 1'b0;
      reject <= 1'b0;
      lvl_d <= '0;
    end else begin
      state <= state_n;
      cmd <= cmd_n;
      cursorPos <= pos_n;
      set <= set_n;
      reject <= rej_n;
      lvl_d <= lvl;
    end
  end
endmodule
